sprite_animator: RTL

- Parametrised Wishbone bus master that drives up to 32 hardware sprites as bouncing objects.
- After reset it programs each sprite's SIZE register. On every frame tick it writes each sprite's POS and image ADDR registers, then advances its position with edge reflection.
- Sits beside the sprite controller as a self-test/demo master on the 32-bit write bus.
- Adds over the previous demo block: configurable sprite count, bounds and addresses; vsync-locked updates; ack timeout; overrun and error status.

---
 rtl/sprite_pkg.sv | 28 ++
 rtl/wishbone_pkg.sv | 38 +++
 rtl/lfsr27.sv | 18 +
 rtl/sprite_animator.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Sprite animator states, register map of one sprite block and the delta helper.
package sprite_pkg;

    typedef enum logic [3:0] {
        SETTLE  = 4'd0,
        SZ_REQ  = 4'd1,
        SZ_ACK  = 4'd2,
        IDLE    = 4'd3,
        POS_REQ = 4'd4,
        POS_ACK = 4'd5,
        UPD     = 4'd6,
        ADR_REQ = 4'd7,
        ADR_ACK = 4'd8,
        NEXT    = 4'd9
    } state_t;

    localparam logic [31:0] REG_POS    = 32'h0;
    localparam logic [31:0] REG_SIZE   = 32'h4;
    localparam logic [31:0] REG_ADDR   = 32'h8;
    localparam logic [31:0] SPR_STRIDE = 32'd16;
    localparam logic [31:0] IMG_STRIDE = 32'h2000;

    // A sprite must always move, so a zero random step becomes +1.
    function automatic logic [11:0] sext_delta(input logic [3:0] n);
        return (n == 4'd0) ? 12'd1 : {{8{n[3]}}, n};
    endfunction

endpackage

// File: rtl/wishbone_pkg.sv
// Shared Wishbone 32-bit request/response types used by the bus masters in this slice.
package wishbone_pkg;

    typedef enum logic [1:0] {
        LINEAR = 2'd0,
        WRAP4  = 2'd1,
        WRAP8  = 2'd2,
        WRAP16 = 2'd3
    } wb_bte_t;

    typedef enum logic [2:0] {
        CLASSIC     = 3'd0,
        CONST_BURST = 3'd1,
        INCR_BURST  = 3'd2,
        END_BURST   = 3'd7
    } wb_cti_t;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        wb_bte_t     bte;
        wb_cti_t     cti;
        logic [7:0]  blen;
        logic [3:0]  cid;
    } wb_write_request32_t;

    typedef struct packed {
        logic        ack;
        logic        err;
        logic        rty;
        logic [31:0] dat;
    } wb_read_response32_t;

endpackage

// File: rtl/lfsr27.sv
// Free-running 27-bit Fibonacci LFSR (x^27 + x^5 + x^2 + x + 1), advances every clock.
module lfsr27 #(
    parameter logic [26:0] SEED = 27'h2A5A5A5
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [26:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else begin
            q <= {q[25:0], q[26] ^ q[4] ^ q[1] ^ q[0]};
        end
    end

endmodule

// File: rtl/sprite_animator.sv
// Wishbone write master that sizes NSPR sprites once, then moves them as bouncing objects per vsync.
//
// state   | meaning
// SETTLE  | let the LFSR run INIT_DLY cycles after reset
// SZ_REQ  | issue SIZE write for sprite idx, latch grid position and random deltas
// SZ_ACK  | wait for ack/timeout of SIZE write
// IDLE    | wait for a vsync rising edge with en_i=1
// POS_REQ | issue POS write for sprite idx
// POS_ACK | wait for ack/timeout of POS write
// UPD     | reflect deltas at bounds and advance position
// ADR_REQ | issue image ADDR write (mirrored image when moving right)
// ADR_ACK | wait for ack/timeout of ADDR write
// NEXT    | step to next sprite or finish the pass
module sprite_animator
    import wishbone_pkg::*;
    import sprite_pkg::*;
#(
    parameter int          NSPR       = 32,
    parameter logic [31:0] REG_BASE   = 32'h0,
    parameter logic [31:0] IMG_BASE   = 32'h00300000,
    parameter logic [31:0] IMG_MIRROR = 32'h1000,
    parameter int          HMIN       = 260,
    parameter int          HMAX       = 980,
    parameter int          VMIN       = 50,
    parameter int          VMAX       = 580,
    parameter int          H0         = 200,
    parameter int          HSTEP      = 70,
    parameter int          V0         = 100,
    parameter int          VSTEP      = 100,
    parameter int          INIT_DLY   = 100000,
    parameter int          TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic                vsync_i,
    output logic                cs,
    output wb_write_request32_t wb_req,
    input  wb_read_response32_t wb_resp,
    output logic                busy_o,
    output logic                ovr_o,
    output logic                err_o,
    output logic [3:0]          state_o
);

    localparam int             IW       = (NSPR > 1) ? $clog2(NSPR) : 1;
    localparam logic [IW-1:0]  LAST     = IW'(NSPR - 1);
    localparam logic [31:0]    DLY_LAST = 32'(INIT_DLY - 1);
    localparam logic [7:0]     TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [11:0]    HMIN12   = 12'(HMIN);
    localparam logic [11:0]    HMAX12   = 12'(HMAX);
    localparam logic [11:0]    VMIN12   = 12'(VMIN);
    localparam logic [11:0]    VMAX12   = 12'(VMAX);

    state_t             state;
    logic [IW-1:0]      idx;
    logic [31:0]        dly_cnt;
    logic [7:0]         tmo_cnt;
    logic [2:0]         vs_q;
    logic [26:0]        lfsr;
    logic [11:0]        hpos   [NSPR];
    logic [11:0]        vpos   [NSPR];
    logic signed [11:0] hdelta [NSPR];
    logic signed [11:0] vdelta [NSPR];

    logic               vs_rise;
    logic [31:0]        idx32, blk_adr, wr_adr, wr_dat;
    logic [11:0]        h_cur, v_cur, h_grid, v_grid;
    logic signed [11:0] hd_cur, vd_cur, hd_upd, vd_upd;
    logic [1:0]         r;
    logic               lfsr_unused, resp_unused;

    lfsr27 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (lfsr)
    );

    assign vs_rise     = vs_q[1] & ~vs_q[2];
    assign cs          = wb_req.cyc;
    assign state_o     = state;
    assign lfsr_unused = ^{lfsr[22:12], lfsr[7:2]};
    assign resp_unused = ^{wb_resp.err, wb_resp.rty, wb_resp.dat};

    always_comb begin
        idx32   = 32'(idx);
        blk_adr = REG_BASE + idx32 * SPR_STRIDE;
        h_cur   = hpos[idx];
        v_cur   = vpos[idx];
        hd_cur  = hdelta[idx];
        vd_cur  = vdelta[idx];
        h_grid  = 12'(H0 + (idx32 % 8) * HSTEP);
        v_grid  = 12'(V0 + (idx32 / 8) * VSTEP);
        r       = lfsr[1:0];
        // Direction-gated reflection: a sprite already heading back inward is left alone.
        hd_upd  = ((h_cur < HMIN12 && hd_cur[11]) || (h_cur > HMAX12 && !hd_cur[11])) ? -hd_cur : hd_cur;
        vd_upd  = ((v_cur < VMIN12 && vd_cur[11]) || (v_cur > VMAX12 && !vd_cur[11])) ? -vd_cur : vd_cur;
        wr_adr  = wb_req.adr;
        wr_dat  = wb_req.dat;
        case (state)
            SZ_REQ: begin
                wr_adr = blk_adr + REG_SIZE;
                wr_dat = {4'h8, 4'hA, 2'b00, r, 2'b00, r, 8'd21, 8'd24};
            end
            POS_REQ: begin
                wr_adr = blk_adr + REG_POS;
                wr_dat = {4'h0, v_cur, 4'h0, h_cur};
            end
            ADR_REQ: begin
                wr_adr = blk_adr + REG_ADDR;
                wr_dat = IMG_BASE + idx32 * IMG_STRIDE + (hd_cur[11] ? 32'h0 : IMG_MIRROR);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SETTLE;
            idx         <= '0;
            dly_cnt     <= '0;
            tmo_cnt     <= '0;
            vs_q        <= '0;
            busy_o      <= 1'b1;
            ovr_o       <= 1'b0;
            err_o       <= 1'b0;
            wb_req.cyc  <= 1'b0;
            wb_req.stb  <= 1'b0;
            wb_req.we   <= 1'b0;
            wb_req.sel  <= 4'hF;
            wb_req.adr  <= '0;
            wb_req.dat  <= '0;
            wb_req.bte  <= LINEAR;
            wb_req.cti  <= CLASSIC;
            wb_req.blen <= '0;
            wb_req.cid  <= 4'd7;
            for (int i = 0; i < NSPR; i++) begin
                hpos[i]   <= '0;
                vpos[i]   <= '0;
                hdelta[i] <= '0;
                vdelta[i] <= '0;
            end
        end else begin
            vs_q <= {vs_q[1:0], vsync_i};
            if (vs_rise && busy_o) ovr_o <= 1'b1;
            case (state)
                SETTLE: begin
                    if (dly_cnt == DLY_LAST) state <= SZ_REQ;
                    else                     dly_cnt <= dly_cnt + 32'd1;
                end
                SZ_REQ, POS_REQ, ADR_REQ: begin
                    if (!wb_resp.ack) begin
                        wb_req.cyc <= 1'b1;
                        wb_req.stb <= 1'b1;
                        wb_req.we  <= 1'b1;
                        wb_req.adr <= wr_adr;
                        wb_req.dat <= wr_dat;
                        tmo_cnt    <= '0;
                        case (state)
                            SZ_REQ: begin
                                hpos[idx]   <= h_grid;
                                vpos[idx]   <= v_grid;
                                hdelta[idx] <= sext_delta(lfsr[26:23]);
                                vdelta[idx] <= sext_delta(lfsr[11:8]);
                                state       <= SZ_ACK;
                            end
                            POS_REQ: state <= POS_ACK;
                            default: state <= ADR_ACK;
                        endcase
                    end
                end
                SZ_ACK, POS_ACK, ADR_ACK: begin
                    // A timed-out write is treated as acked so a dead slave cannot stall the pass.
                    if (wb_resp.ack || tmo_cnt == TMO_LAST) begin
                        wb_req.cyc <= 1'b0;
                        wb_req.stb <= 1'b0;
                        wb_req.we  <= 1'b0;
                        if (!wb_resp.ack) err_o <= 1'b1;
                        case (state)
                            SZ_ACK: begin
                                if (idx == LAST) begin
                                    idx    <= '0;
                                    busy_o <= 1'b0;
                                    state  <= IDLE;
                                end else begin
                                    idx   <= idx + 1'b1;
                                    state <= SZ_REQ;
                                end
                            end
                            POS_ACK: state <= UPD;
                            default: state <= NEXT;
                        endcase
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                IDLE: begin
                    if (vs_rise && en_i) begin
                        busy_o <= 1'b1;
                        state  <= POS_REQ;
                    end
                end
                UPD: begin
                    hdelta[idx] <= hd_upd;
                    vdelta[idx] <= vd_upd;
                    hpos[idx]   <= h_cur + $unsigned(hd_upd);
                    vpos[idx]   <= v_cur + $unsigned(vd_upd);
                    state       <= ADR_REQ;
                end
                NEXT: begin
                    if (idx == LAST) begin
                        idx    <= '0;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= POS_REQ;
                    end
                end
                default: state <= SETTLE;
            endcase
        end
    end

endmodule
